// File: rtl/mmio_uart_hub_pkg.sv
// Shared definitions for the MMIO serial hub: STATUS bit layout and
// register-select encoding within a channel's two-address slot.
package mmio_uart_hub_pkg;

  localparam int unsigned ST_TXE = 0;
  localparam int unsigned ST_RXA = 1;
  localparam int unsigned ST_OVF = 2;
  localparam int unsigned ST_OVR = 3;

  // Low offset bit selects the register inside a channel slot.
  typedef enum logic {
    RegData   = 1'b0,
    RegStatus = 1'b1
  } reg_sel_e;

  function automatic logic [15:0] pack_status(input logic tx_ovr, input logic rx_ovf,
                                              input logic rx_avail, input logic tx_empty);
    logic [15:0] s;
    s         = '0;
    s[ST_TXE] = tx_empty;
    s[ST_RXA] = rx_avail;
    s[ST_OVF] = rx_ovf;
    s[ST_OVR] = tx_ovr;
    return s;
  endfunction

endpackage

// File: rtl/mmio_rx_fifo.sv
// Per-channel receive FIFO. A pop of an empty FIFO is ignored; a push into a
// full FIFO succeeds only when a pop frees a slot in the same cycle.
module mmio_rx_fifo
  import mmio_uart_hub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_ovf_set
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop     = i_pop && !o_empty;
  assign w_push    = i_push && (!o_full || w_pop);
  assign o_ovf_set = i_push && !w_push;
  assign o_dout    = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_hub.sv
// MMIO decoder and serial-channel hub: port A peeks, port B reads/writes with
// pop/push/clear side effects; everything outside the window goes to RAM.
module mmio_uart_hub
  import mmio_uart_hub_pkg::*;
#(
  parameter int unsigned NCH        = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] BASE_ADDR  = 16'hBF00
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [15:0]      i_addr_a,
  input  logic [15:0]      i_ram_rdata_a,
  output logic [15:0]      o_rdata_a,
  output logic             o_mmio_hit_a,
  input  logic [15:0]      i_addr_b,
  input  logic             i_rd_b,
  input  logic             i_wr_b,
  input  logic [15:0]      i_wdata_b,
  input  logic [15:0]      i_ram_rdata_b,
  output logic [15:0]      o_rdata_b,
  output logic             o_mmio_hit_b,
  input  logic [NCH-1:0]   i_rx_valid,
  input  logic [8*NCH-1:0] i_rx_data,
  output logic [NCH-1:0]   o_tx_valid,
  output logic [8*NCH-1:0] o_tx_data,
  input  logic [NCH-1:0]   i_tx_ready
);

  localparam logic [15:0] WinSize = 16'(2 * NCH);

  logic [15:0]          w_off_a;
  logic [15:0]          w_off_b;
  logic                 w_hit_a;
  logic                 w_hit_b;
  logic [2:0]           w_ch_a;
  logic [2:0]           w_ch_b;
  reg_sel_e             w_sel_a;
  reg_sel_e             w_sel_b;

  logic [NCH-1:0]       w_pop;
  logic [NCH-1:0]       w_stat_rd;
  logic [NCH-1:0]       w_wr_data;
  logic [NCH-1:0]       w_tx_free;
  logic [NCH-1:0]       w_ovr_set;
  logic [NCH-1:0]       w_ovf_set;
  logic [NCH-1:0]       w_empty;
  logic [NCH-1:0]       w_full;
  logic [NCH-1:0][7:0]  w_dout;
  logic [NCH-1:0][15:0] w_status;
  logic [NCH-1:0][15:0] w_data;

  logic [NCH-1:0]       r_tx_valid;
  logic [NCH-1:0][7:0]  r_tx_data;
  logic [NCH-1:0]       r_rx_ovf;
  logic [NCH-1:0]       r_tx_ovr;

  logic                 w_unused;

  // Lower-bound check guards against wraparound of the subtraction.
  assign w_off_a = i_addr_a - BASE_ADDR;
  assign w_off_b = i_addr_b - BASE_ADDR;
  assign w_hit_a = (i_addr_a >= BASE_ADDR) && (w_off_a < WinSize);
  assign w_hit_b = (i_addr_b >= BASE_ADDR) && (w_off_b < WinSize);
  assign w_ch_a  = w_off_a[3:1];
  assign w_ch_b  = w_off_b[3:1];
  assign w_sel_a = reg_sel_e'(w_off_a[0]);
  assign w_sel_b = reg_sel_e'(w_off_b[0]);

  assign o_mmio_hit_a = w_hit_a;
  assign o_mmio_hit_b = w_hit_b;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic w_sel_ch;
    logic w_rd_only;

    assign w_sel_ch  = w_hit_b && (w_ch_b == 3'(c));
    // A simultaneous write suppresses every read side effect.
    assign w_rd_only = w_sel_ch && i_rd_b && !i_wr_b;

    assign w_pop[c]     = w_rd_only && (w_sel_b == RegData);
    assign w_stat_rd[c] = w_rd_only && (w_sel_b == RegStatus);
    assign w_wr_data[c] = w_sel_ch && i_wr_b && (w_sel_b == RegData);
    assign w_tx_free[c] = !r_tx_valid[c] || i_tx_ready[c];
    assign w_ovr_set[c] = w_wr_data[c] && !w_tx_free[c];

    assign w_status[c] = pack_status(r_tx_ovr[c], r_rx_ovf[c], !w_empty[c], !r_tx_valid[c]);
    assign w_data[c]   = w_empty[c] ? 16'h0000 : {8'h00, w_dout[c]};

    mmio_rx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_push    (i_rx_valid[c]),
      .i_din     (i_rx_data[8*c +: 8]),
      .i_pop     (w_pop[c]),
      .o_dout    (w_dout[c]),
      .o_empty   (w_empty[c]),
      .o_full    (w_full[c]),
      .o_ovf_set (w_ovf_set[c])
    );
  end

  always_comb begin
    o_rdata_a = i_ram_rdata_a;
    o_rdata_b = i_ram_rdata_b;
    for (int c = 0; c < NCH; c++) begin
      if (w_hit_a && (w_ch_a == 3'(c))) begin
        o_rdata_a = (w_sel_a == RegStatus) ? w_status[c] : w_data[c];
      end
      if (w_hit_b && (w_ch_b == 3'(c))) begin
        o_rdata_b = (w_sel_b == RegStatus) ? w_status[c] : w_data[c];
      end
    end
  end

  // Sticky flags give priority to a new set over a status-read clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_valid <= '0;
      r_tx_data  <= '0;
      r_rx_ovf   <= '0;
      r_tx_ovr   <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_wr_data[c] && w_tx_free[c]) begin
          r_tx_valid[c] <= 1'b1;
          r_tx_data[c]  <= i_wdata_b[7:0];
        end else if (r_tx_valid[c] && i_tx_ready[c]) begin
          r_tx_valid[c] <= 1'b0;
        end

        if (w_ovr_set[c]) begin
          r_tx_ovr[c] <= 1'b1;
        end else if (w_stat_rd[c]) begin
          r_tx_ovr[c] <= 1'b0;
        end

        if (w_ovf_set[c]) begin
          r_rx_ovf[c] <= 1'b1;
        end else if (w_stat_rd[c]) begin
          r_rx_ovf[c] <= 1'b0;
        end
      end
    end
  end

  assign o_tx_valid = r_tx_valid;
  assign o_tx_data  = r_tx_data;

  assign w_unused = ^{i_wdata_b[15:8], w_full};

endmodule

// File: tb/tb_mmio_uart_hub.sv
// Self-checking bench for mmio_uart_hub: directed scenarios with fixed
// expectations plus a randomized run against a queue-based reference model.
module tb_mmio_uart_hub;

  localparam int unsigned NCH   = 2;
  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] BASE  = 16'hBF00;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [15:0]      i_addr_a;
  logic [15:0]      i_ram_rdata_a;
  logic [15:0]      o_rdata_a;
  logic             o_mmio_hit_a;
  logic [15:0]      i_addr_b;
  logic             i_rd_b;
  logic             i_wr_b;
  logic [15:0]      i_wdata_b;
  logic [15:0]      i_ram_rdata_b;
  logic [15:0]      o_rdata_b;
  logic             o_mmio_hit_b;
  logic [NCH-1:0]   i_rx_valid;
  logic [8*NCH-1:0] i_rx_data;
  logic [NCH-1:0]   o_tx_valid;
  logic [8*NCH-1:0] o_tx_data;
  logic [NCH-1:0]   i_tx_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]     m_q [NCH][$];
  logic [NCH-1:0] m_txv;
  logic [7:0]     m_txd [NCH];
  logic [NCH-1:0] m_ovf;
  logic [NCH-1:0] m_ovr;

  mmio_uart_hub #(
    .NCH        (NCH),
    .FIFO_DEPTH (DEPTH),
    .BASE_ADDR  (BASE)
  ) u_dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_addr_a      (i_addr_a),
    .i_ram_rdata_a (i_ram_rdata_a),
    .o_rdata_a     (o_rdata_a),
    .o_mmio_hit_a  (o_mmio_hit_a),
    .i_addr_b      (i_addr_b),
    .i_rd_b        (i_rd_b),
    .i_wr_b        (i_wr_b),
    .i_wdata_b     (i_wdata_b),
    .i_ram_rdata_b (i_ram_rdata_b),
    .o_rdata_b     (o_rdata_b),
    .o_mmio_hit_b  (o_mmio_hit_b),
    .i_rx_valid    (i_rx_valid),
    .i_rx_data     (i_rx_data),
    .o_tx_valid    (o_tx_valid),
    .o_tx_data     (o_tx_data),
    .i_tx_ready    (i_tx_ready)
  );

  always #5 i_clk = ~i_clk;

  function automatic bit exp_hit(input logic [15:0] addr);
    int off;
    off = int'(addr) - int'(BASE);
    return (off >= 0) && (off < int'(2 * NCH));
  endfunction

  function automatic logic [15:0] exp_read(input logic [15:0] addr, input logic [15:0] ram);
    int off;
    int c;
    if (!exp_hit(addr)) return ram;
    off = int'(addr) - int'(BASE);
    c   = off / 2;
    if (off % 2 == 1) return {12'h000, m_ovr[c], m_ovf[c], m_q[c].size() != 0, !m_txv[c]};
    if (m_q[c].size() == 0) return 16'h0000;
    return {8'h00, m_q[c][0]};
  endfunction

  // Applies the clock-edge rules to the model using the inputs seen at the edge.
  task automatic model_edge();
    int  off;
    int  cb;
    bit  hit;
    bit  st;
    bit  pop;
    bit  wrd;
    bit  strd;
    bit  hs;
    bit  ovf_set;
    bit  ovr_set;
    int  sz;
    if (i_rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_q[c].delete();
        m_txd[c] = 8'h00;
      end
      m_txv = '0;
      m_ovf = '0;
      m_ovr = '0;
      return;
    end
    hit = exp_hit(i_addr_b);
    off = int'(i_addr_b) - int'(BASE);
    cb  = hit ? off / 2 : -1;
    st  = hit && (off % 2 == 1);
    for (int c = 0; c < NCH; c++) begin
      sz      = m_q[c].size();
      pop     = (cb == c) && i_rd_b && !i_wr_b && !st && (sz > 0);
      strd    = (cb == c) && i_rd_b && !i_wr_b && st;
      wrd     = (cb == c) && i_wr_b && !st;
      hs      = m_txv[c] && i_tx_ready[c];
      ovf_set = 1'b0;
      ovr_set = 1'b0;
      if (pop) void'(m_q[c].pop_front());
      if (i_rx_valid[c]) begin
        if (sz < int'(DEPTH) || pop) m_q[c].push_back(i_rx_data[8*c +: 8]);
        else ovf_set = 1'b1;
      end
      if (wrd) begin
        if (!m_txv[c] || hs) begin
          m_txv[c] = 1'b1;
          m_txd[c] = i_wdata_b[7:0];
        end else begin
          ovr_set = 1'b1;
        end
      end else if (hs) begin
        m_txv[c] = 1'b0;
      end
      if (ovf_set) m_ovf[c] = 1'b1;
      else if (strd) m_ovf[c] = 1'b0;
      if (ovr_set) m_ovr[c] = 1'b1;
      else if (strd) m_ovr[c] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    i_rd_b     = 1'b0;
    i_wr_b     = 1'b0;
    i_rx_valid = '0;
    i_tx_ready = '0;
  endtask

  task automatic b_read(input logic [15:0] addr, output logic [15:0] data);
    i_addr_b = addr;
    i_rd_b   = 1'b1;
    #1;
    data = o_rdata_b;
    tick();
    i_rd_b = 1'b0;
  endtask

  task automatic b_write(input logic [15:0] addr, input logic [15:0] data);
    i_addr_b  = addr;
    i_wdata_b = data;
    i_wr_b    = 1'b1;
    tick();
    i_wr_b = 1'b0;
  endtask

  task automatic rx_push(input int c, input logic [7:0] b);
    i_rx_valid[c]        = 1'b1;
    i_rx_data[8*c +: 8]  = b;
    tick();
    i_rx_valid[c] = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    i_rst = 1'b1;
    idle();
    i_addr_a = 16'h0000; i_addr_b = 16'h0000; i_wdata_b = 16'h0000;
    i_ram_rdata_a = 16'h0000; i_ram_rdata_b = 16'h0000; i_rx_data = '0;
    tick();
    tick();
    i_rst = 1'b0;
    n_checks++;
    if (o_tx_valid !== 2'b00 || o_tx_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_tx: got valid=%b data=%h expected 00/0000", o_tx_valid, o_tx_data);
    end
    b_read(16'hBF01, d);
    n_checks++;
    if (d !== 16'h0001) begin
      n_fail++; $display("FAIL reset_status: got %h expected 0001", d);
    end
    b_read(16'hBF00, d);
    n_checks++;
    if (d !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data_empty: got %h expected 0000", d);
    end
    b_read(16'hBF01, d);
    n_checks++;
    if (d !== 16'h0001) begin
      n_fail++; $display("FAIL reset_status_after_empty_read: got %h expected 0001", d);
    end
  endtask

  task automatic test_rx_basic();
    logic [15:0] d;
    rx_push(0, 8'h41);
    rx_push(0, 8'h42);
    b_read(16'hBF00, d);
    n_checks++;
    if (d !== 16'h0041) begin n_fail++; $display("FAIL rx_first: got %h expected 0041", d); end
    b_read(16'hBF00, d);
    n_checks++;
    if (d !== 16'h0042) begin n_fail++; $display("FAIL rx_second: got %h expected 0042", d); end
    b_read(16'hBF01, d);
    n_checks++;
    if (d !== 16'h0001) begin n_fail++; $display("FAIL rx_status_drained: got %h expected 0001", d); end
  endtask

  task automatic test_rx_overflow();
    logic [15:0] d;
    for (int i = 0; i < 5; i++) rx_push(1, 8'hA0 + 8'(i));
    b_read(16'hBF03, d);
    n_checks++;
    if (d !== 16'h0007) begin n_fail++; $display("FAIL ovf_status: got %h expected 0007", d); end
    b_read(16'hBF03, d);
    n_checks++;
    if (d !== 16'h0003) begin n_fail++; $display("FAIL ovf_cleared: got %h expected 0003", d); end
    for (int i = 0; i < 4; i++) begin
      b_read(16'hBF02, d);
      n_checks++;
      if (d !== {8'h00, 8'hA0 + 8'(i)}) begin
        n_fail++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, d, {8'h00, 8'hA0 + 8'(i)});
      end
    end
    b_read(16'hBF02, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL ovf_empty_after: got %h expected 0000", d); end
  endtask

  task automatic test_tx();
    logic [15:0] d;
    b_write(16'hBF00, 16'h1255);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (o_tx_valid[0] !== 1'b1 || o_tx_data[7:0] !== 8'h55) begin
        n_fail++;
        $display("FAIL tx_hold[%0d]: got valid=%b data=%h expected 1/55", i, o_tx_valid[0],
                 o_tx_data[7:0]);
      end
      tick();
    end
    b_write(16'hBF00, 16'h0066);
    n_checks++;
    if (o_tx_data[7:0] !== 8'h55) begin
      n_fail++; $display("FAIL tx_ovr_keep: got %h expected 55", o_tx_data[7:0]);
    end
    b_read(16'hBF01, d);
    n_checks++;
    if (d !== 16'h0008) begin n_fail++; $display("FAIL tx_ovr_status: got %h expected 0008", d); end
    i_tx_ready[0] = 1'b1;
    tick();
    i_tx_ready[0] = 1'b0;
    n_checks++;
    if (o_tx_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL tx_drop: got valid=%b expected 0", o_tx_valid[0]);
    end
    b_write(16'hBF00, 16'h0077);
    i_tx_ready[0] = 1'b1;
    b_write(16'hBF00, 16'h0088);
    i_tx_ready[0] = 1'b0;
    n_checks++;
    if (o_tx_valid[0] !== 1'b1 || o_tx_data[7:0] !== 8'h88) begin
      n_fail++;
      $display("FAIL tx_hs_and_write: got valid=%b data=%h expected 1/88", o_tx_valid[0],
               o_tx_data[7:0]);
    end
    b_read(16'hBF01, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL tx_hs_no_ovr: got %h expected 0000", d); end
    b_write(16'hBF01, 16'h00FF);
    n_checks++;
    if (o_tx_data[7:0] !== 8'h88) begin
      n_fail++; $display("FAIL tx_status_write_ignored: got %h expected 88", o_tx_data[7:0]);
    end
    i_tx_ready[0] = 1'b1;
    tick();
    i_tx_ready[0] = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) rx_push(0, 8'h10 + 8'(i));
    i_rx_valid[0]    = 1'b1;
    i_rx_data[7:0]   = 8'h14;
    i_addr_b         = 16'hBF00;
    i_rd_b           = 1'b1;
    #1;
    d = o_rdata_b;
    tick();
    idle();
    n_checks++;
    if (d !== 16'h0010) begin n_fail++; $display("FAIL full_pp_head: got %h expected 0010", d); end
    b_read(16'hBF01, d);
    n_checks++;
    if (d !== 16'h0003) begin n_fail++; $display("FAIL full_pp_no_ovf: got %h expected 0003", d); end
    for (int i = 1; i < 5; i++) begin
      b_read(16'hBF00, d);
      n_checks++;
      if (d !== {8'h00, 8'h10 + 8'(i)}) begin
        n_fail++; $display("FAIL full_pp_order[%0d]: got %h expected %h", i, d, {8'h00, 8'h10 + 8'(i)});
      end
    end
    b_read(16'hBF00, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL full_pp_count4: got %h expected 0000", d); end
    i_rx_valid[0]  = 1'b1;
    i_rx_data[7:0] = 8'h21;
    b_read(16'hBF00, d);
    i_rx_valid[0] = 1'b0;
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL empty_push_read: got %h expected 0000", d); end
    b_read(16'hBF00, d);
    n_checks++;
    if (d !== 16'h0021) begin n_fail++; $display("FAIL empty_push_kept: got %h expected 0021", d); end
  endtask

  task automatic test_port_a_and_ram();
    logic [15:0] d;
    logic [15:0] r;
    rx_push(0, 8'h5A);
    i_addr_a = 16'hBF00;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (o_rdata_a !== 16'h005A || o_mmio_hit_a !== 1'b1) begin
        n_fail++; $display("FAIL peek_a[%0d]: got %h hit=%b expected 005A/1", i, o_rdata_a, o_mmio_hit_a);
      end
      tick();
    end
    b_read(16'hBF00, d);
    n_checks++;
    if (d !== 16'h005A) begin n_fail++; $display("FAIL peek_no_pop: got %h expected 005A", d); end
    r = 16'($urandom);
    i_ram_rdata_b = r;
    i_ram_rdata_a = ~r;
    i_addr_b = 16'h1234;
    i_addr_a = 16'hBF04;
    #1;
    n_checks++;
    if (o_rdata_b !== r || o_mmio_hit_b !== 1'b0) begin
      n_fail++; $display("FAIL ram_pass_b: got %h hit=%b expected %h/0", o_rdata_b, o_mmio_hit_b, r);
    end
    n_checks++;
    if (o_rdata_a !== ~r || o_mmio_hit_a !== 1'b0) begin
      n_fail++; $display("FAIL window_end_a: got %h hit=%b expected %h/0", o_rdata_a, o_mmio_hit_a, ~r);
    end
    i_addr_b = 16'hBEFF;
    #1;
    n_checks++;
    if (o_rdata_b !== r || o_mmio_hit_b !== 1'b0) begin
      n_fail++; $display("FAIL below_base_b: got %h hit=%b expected %h/0", o_rdata_b, o_mmio_hit_b, r);
    end
    tick();
  endtask

  task automatic test_reset_mid_tx();
    b_write(16'hBF02, 16'h0099);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    n_checks++;
    if (o_tx_valid !== 2'b00 || o_tx_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_tx: got valid=%b data=%h expected 00/0000", o_tx_valid, o_tx_data);
    end
  endtask

  function automatic logic [15:0] rand_addr();
    int k;
    k = int'($urandom_range(0, 7));
    if (k <= 3) return BASE + 16'(k);
    if (k == 4) return BASE - 16'd1;
    if (k == 5) return BASE + 16'(2 * NCH);
    return 16'($urandom);
  endfunction

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      i_addr_a      = rand_addr();
      i_addr_b      = rand_addr();
      i_rd_b        = ($urandom_range(0, 1) == 1);
      i_wr_b        = ($urandom_range(0, 3) == 0);
      i_wdata_b     = 16'($urandom);
      i_rx_valid    = NCH'($urandom);
      i_rx_data     = (8*NCH)'($urandom);
      i_tx_ready    = NCH'($urandom) & NCH'($urandom);
      i_ram_rdata_a = 16'($urandom);
      i_ram_rdata_b = 16'($urandom);
      #1;
      n_checks++;
      if (o_rdata_a !== exp_read(i_addr_a, i_ram_rdata_a) || o_mmio_hit_a !== exp_hit(i_addr_a)) begin
        n_fail++;
        $display("FAIL rand_a[%0d]: addr=%h got %h/%b expected %h/%b", n, i_addr_a, o_rdata_a,
                 o_mmio_hit_a, exp_read(i_addr_a, i_ram_rdata_a), exp_hit(i_addr_a));
      end
      n_checks++;
      if (o_rdata_b !== exp_read(i_addr_b, i_ram_rdata_b) || o_mmio_hit_b !== exp_hit(i_addr_b)) begin
        n_fail++;
        $display("FAIL rand_b[%0d]: addr=%h got %h/%b expected %h/%b", n, i_addr_b, o_rdata_b,
                 o_mmio_hit_b, exp_read(i_addr_b, i_ram_rdata_b), exp_hit(i_addr_b));
      end
      n_checks++;
      if (o_tx_valid !== m_txv) begin
        n_fail++; $display("FAIL rand_txv[%0d]: got %b expected %b", n, o_tx_valid, m_txv);
      end
      for (int c = 0; c < NCH; c++) begin
        if (m_txv[c]) begin
          n_checks++;
          if (o_tx_data[8*c +: 8] !== m_txd[c]) begin
            n_fail++;
            $display("FAIL rand_txd[%0d] ch%0d: got %h expected %h", n, c, o_tx_data[8*c +: 8], m_txd[c]);
          end
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_rx_overflow();
    test_tx();
    test_full_push_pop();
    test_port_a_and_ram();
    test_reset_mid_tx();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
